// File: rtl/mips_regfile_sb.sv
// Multi-read-port MIPS register file with write-back bypass and a per-register pending scoreboard.
// Define MIPS_REGFILE_RESET_EN to also clear the register array on reset.
module mips_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NRD-1:0]                rd_en,
  input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]         rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic                          issue_valid,
  input  logic [$clog2(NREGS)-1:0]      issue_rd,
  output logic                          issue_stall,
  input  logic                          wb_en,
  input  logic [$clog2(NREGS)-1:0]      wb_rd,
  input  logic [DATA_W-1:0]             wb_data,
  output logic [$clog2(NREGS):0]        pend_count
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_IDX = '0;

  typedef logic [AW:0] cnt_t;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_pending;
  logic [NREGS-1:0]  w_pending_nxt;
  cnt_t              r_pend_count;
  cnt_t              w_pend_count_nxt;
  logic              w_wb_live;
  logic              w_issue_stall;
  logic              w_issue_acc;

  assign w_wb_live     = wb_en && (wb_rd != ZERO_IDX);
  // A write-back retiring the same destination this cycle frees it for the new issue.
  assign w_issue_stall = issue_valid && (issue_rd != ZERO_IDX) && r_pending[issue_rd]
                         && !(wb_en && (wb_rd == issue_rd));
  assign w_issue_acc   = issue_valid && !w_issue_stall && (issue_rd != ZERO_IDX);

  // Issue is applied after write-back so a same-index issue keeps the bit set for its new owner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    w_pending_nxt    = r_pending;
    w_pend_count_nxt = '0;
    if (w_wb_live)   w_pending_nxt[wb_rd]    = 1'b0;
    if (w_issue_acc) w_pending_nxt[issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      w_pend_count_nxt = w_pend_count_nxt + cnt_t'(w_pending_nxt[i]);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending    <= '0;
      r_pend_count <= '0;
    end else begin
      r_pending    <= w_pending_nxt;
      r_pend_count <= w_pend_count_nxt;
    end
  end

`ifdef MIPS_REGFILE_RESET_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_live) begin
      r_regs[wb_rd] <= wb_data;
    end
  end
`else
  // NOTE: the array has no reset path so it can map onto RAM; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (reset && w_wb_live) r_regs[wb_rd] <= wb_data;
  end
`endif

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] r_data;

    assign w_addr                      = rd_addr[p*AW +: AW];
    assign rd_busy[p]                  = r_pending[w_addr] && !(wb_en && (wb_rd == w_addr));
    assign rd_data[p*DATA_W +: DATA_W] = r_data;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_data <= '0;
      end else if (rd_en[p]) begin
        if (w_addr == ZERO_IDX)                    r_data <= '0;
        else if (w_wb_live && (wb_rd == w_addr))   r_data <= wb_data;
        else                                       r_data <= r_regs[w_addr];
      end
    end
  end

  assign issue_stall = w_issue_stall;
  assign pend_count  = r_pend_count;

endmodule
